jtag_host: RTL and testbench
============================

# jtag_host

Host-side JTAG initiator that drives the `jtag_TCK/TMS/TDI` pins and samples `jtag_TDO`, i.e. the transmitting end of the TAP protocol served by `jtag_top`. It turns single commands into complete TAP traversals starting and ending in Run-Test/Idle: TAP reset, IR scan or DR scan. It is used on FPGA boards and benches to load programs and halt or reset the core through the debug module, with no external JTAG probe.

## Interface
- `CLK_DIV`, 2: clk cycles per TCK half-period; minimum 1.
- `IR_LEN`, 5: instruction register length, informational; IR scan uses `cmd_len_i`.
- `DR_MAX`, 40: maximum scan length (DMI: 6 addr + 32 data + 2 op).
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid_i`  in  1  command request.
- `cmd_ready_o`  out  1  high only in IDLE.
- `cmd_type_i`  in  2  `JtagCmdReset`=00, `JtagCmdIr`=01, `JtagCmdDr`=10; 11 is treated as reset.
- `cmd_len_i`  in  6  scan length in bits.
- `cmd_data_i`  in  DR_MAX  TDI bits, LSB shifted first.
- `rsp_valid_o`  out  1  one-cycle pulse at command end.
- `rsp_data_o`  out  DR_MAX  captured TDO; first bit shifted in at bit 0, right-aligned, upper bits 0.
- `jtag_TCK`, `jtag_TMS`, `jtag_TDI`  out  1  TAP pins.
- `jtag_TDO`  in  1  TAP data out.

## Operation
- States: IDLE, PRE, SHIFT, POST, DONE.
- Handshake: a command is accepted on `cmd_valid_i & cmd_ready_o`. Type, length and data are latched at acceptance.
- Length rules:
  - `cmd_len_i` > DR_MAX is clamped to DR_MAX.
  - `cmd_len_i` = 0 for an IR or DR scan goes straight to DONE. No pin activity; response data is 0.
- TMS sequences, one TMS value per TCK cycle, all ending in Run-Test/Idle:
  - Reset: 1,1,1,1,1,0. Six TCK cycles, all in PRE. No SHIFT or POST.
  - IR scan, PRE: 1,1,0,0.
  - DR scan, PRE: 1,0,0.
  - SHIFT, `len` cycles: TMS=0, except TMS=1 on the last bit (Exit1).
  - POST: 1,0 (Update, Idle).
- Total TCK cycles N: reset 6; IR 6+len; DR 5+len.
- TDI carries `cmd_data_i[i]` on shift bit i, and 0 outside SHIFT.
- TDO is sampled only on SHIFT rising edges. Sample i goes to `rsp_data_o[i]`.
- DONE lasts one cycle. It drives `rsp_valid_o`=1, then the block returns to IDLE.
- `rsp_data_o` holds its value until the next DONE.
- The block never issues a TAP reset on its own. Software or the bench issues a reset command first.

## Timing
- TCK cycle = CLK_DIV clk cycles low, then CLK_DIV high. TCK idles low.
- TMS and TDI change only together with the TCK fall, or at the first low phase. They are stable across every rising edge.
- TDO is registered in the clk cycle in which TCK goes 0→1.
- Acceptance at edge k:
  - First low phase starts at k+1.
  - First TCK rise at k+1+CLK_DIV.
  - `rsp_valid_o` high during cycle k+1+2·N·CLK_DIV.
  - `cmd_ready_o` returns high in the cycle after `rsp_valid_o`.
- len=0: `rsp_valid_o` at k+1.
- Reset values: `cmd_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0, `jtag_TCK`=0, `jtag_TMS`=1, `jtag_TDI`=0. State is IDLE.
- After any completed command TMS rests at 0.
- `rst` mid-command aborts at once: pins go to reset values, no response is produced, and the TAP state is undefined.
- `cmd_valid_i` while busy is ignored. There is no queueing.

## Structure
- Command encodings `JtagCmdReset/Ir/Dr` and the DR_MAX default go in `defines.v`.
- Sub-module `jtag_host_tck`: CLK_DIV counter producing the `tck_rise` and `tck_fall` strobes and the TCK level. It is enabled outside IDLE and DONE.
- Main FSM holds a bit counter (6 bits), a TMS-sequence index, and a shift register for TDI and TDO.

## Test plan
- CLK_DIV=2, reset command:
  - TMS 1,1,1,1,1,0 across 6 TCK rises.
  - `rsp_valid_o` exactly 25 cycles after acceptance; data 0.
- IR scan, len 5, data 5'h11:
  - TMS 1,1,0,0,0,0,0,0,1,1,0.
  - TDI in SHIFT 1,0,0,0,1.
  - 11 TCK cycles.
- DR scan, len 40, against a bench TAP model that captures 40'h12_3456_789A:
  - `rsp_data_o`=40'h12_3456_789A.
  - The model's update register equals `cmd_data_i`.
- Back-to-back commands with `cmd_valid_i` held high:
  - Second command accepted exactly one cycle after the first `rsp_valid_o` pulse.
  - No TCK edge while IDLE.
- `rst` asserted mid-SHIFT:
  - Same cycle: TCK=0, TMS=1, TDI=0.
  - No `rsp_valid_o`.
  - `cmd_ready_o`=1 after release.
- len 0 DR scan:
  - No TCK toggles; `rsp_valid_o` at k+1 with data 0.
- len 50 DR scan:
  - Behaves as len 40 (45 TCK cycles).

Source files
------------

// File: rtl/jtag_host_pkg.sv
// Shared types and TMS-sequence helpers for the host-side JTAG initiator.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        JtagCmdReset = 2'b00,
        JtagCmdIr    = 2'b01,
        JtagCmdDr    = 2'b10
    } jtag_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StShift,
        StPost,
        StDone
    } jtag_state_e;

    localparam int unsigned JtagDrMaxDefault = 40;

    // The unused encoding 2'b11 falls back to a TAP reset.
    function automatic jtag_cmd_e cmd_decode(input logic [1:0] raw);
        jtag_cmd_e cmd;
        case (raw)
            2'b01:   cmd = JtagCmdIr;
            2'b10:   cmd = JtagCmdDr;
            default: cmd = JtagCmdReset;
        endcase
        return cmd;
    endfunction

    // Index of the final TCK cycle of the lead-in sequence.
    function automatic logic [2:0] pre_last(input jtag_cmd_e cmd);
        logic [2:0] last;
        case (cmd)
            JtagCmdIr: last = 3'd3;
            JtagCmdDr: last = 3'd2;
            default:   last = 3'd5;
        endcase
        return last;
    endfunction

    // Lead-in TMS: reset 1,1,1,1,1,0; IR 1,1,0,0; DR 1,0,0.
    function automatic logic pre_tms(input jtag_cmd_e cmd, input logic [2:0] idx);
        logic tms;
        case (cmd)
            JtagCmdIr: tms = (idx < 3'd2);
            JtagCmdDr: tms = (idx == 3'd0);
            default:   tms = (idx < 3'd5);
        endcase
        return tms;
    endfunction

endpackage

// File: rtl/jtag_host_tck.sv
// TCK generator: CLK_DIV clk cycles per half-period, low phase first, idles low.
module jtag_host_tck #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tck_q, tck_d;
    logic            wrap;

    assign wrap = en_i && (cnt_q == CntLast);

    always_comb begin
        cnt_d = '0;
        tck_d = 1'b0;
        if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CntW'(1);
            tck_d = wrap ? ~tck_q : tck_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    // Strobes flag the clk edge on which TCK toggles.
    assign rise_o = wrap && !tck_q;
    assign fall_o = wrap && tck_q;
    assign tck_o  = tck_q;

endmodule

// File: rtl/jtag_host.sv
// Host-side JTAG initiator: turns one command into a full TAP traversal
// (reset, IR scan or DR scan) that starts and ends in Run-Test/Idle.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned IR_LEN  = 5,
    parameter int unsigned DR_MAX  = JtagDrMaxDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_type_i,
    input  logic [5:0]        cmd_len_i,
    input  logic [DR_MAX-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    output logic [DR_MAX-1:0] rsp_data_o,
    output logic              jtag_TCK,
    output logic              jtag_TMS,
    output logic              jtag_TDI,
    input  logic              jtag_TDO
);

    if (IR_LEN > DR_MAX || DR_MAX > 63 || DR_MAX < 2 || CLK_DIV < 1) begin : g_param_check
        $error("jtag_host: invalid CLK_DIV/IR_LEN/DR_MAX combination");
    end

    localparam logic [6:0] DrMaxW = 7'(DR_MAX);

    jtag_state_e       state_q, state_d;
    jtag_cmd_e         type_q, type_d;
    logic [5:0]        len_q, len_d;
    logic [5:0]        bit_q, bit_d;
    logic [2:0]        idx_q, idx_d;
    logic [DR_MAX-1:0] shreg_q, shreg_d;
    logic [DR_MAX-1:0] rsp_q, rsp_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;

    jtag_cmd_e         acc_type;
    logic [5:0]        acc_len;
    logic              tck_en, tck_rise, tck_fall;

    assign acc_type = cmd_decode(cmd_type_i);
    assign acc_len  = (cmd_len_i > 6'(DR_MAX)) ? 6'(DR_MAX) : cmd_len_i;
    assign tck_en   = (state_q == StPre) || (state_q == StShift) || (state_q == StPost);

    jtag_host_tck #(
        .CLK_DIV(CLK_DIV)
    ) u_tck (
        .clk   (clk),
        .rst   (rst),
        .en_i  (tck_en),
        .tck_o (jtag_TCK),
        .rise_o(tck_rise),
        .fall_o(tck_fall)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        len_d   = len_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        rsp_d   = rsp_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    type_d  = acc_type;
                    len_d   = acc_len;
                    shreg_d = cmd_data_i;
                    idx_d   = '0;
                    bit_d   = '0;
                    if (acc_type != JtagCmdReset && acc_len == 6'd0) begin
                        rsp_d   = '0;
                        state_d = StDone;
                    end else begin
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                        state_d = StPre;
                    end
                end
            end
            StPre: begin
                if (tck_fall) begin
                    if (idx_q == pre_last(type_q)) begin
                        if (type_q == JtagCmdReset) begin
                            tms_d   = 1'b0;
                            rsp_d   = '0;
                            state_d = StDone;
                        end else begin
                            bit_d   = '0;
                            tms_d   = (len_q == 6'd1);
                            tdi_d   = shreg_q[0];
                            state_d = StShift;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tms_d = pre_tms(type_q, idx_q + 3'd1);
                    end
                end
            end
            StShift: begin
                // TDO enters at the top; after len bits it is right-aligned on exit.
                if (tck_rise) begin
                    shreg_d = {jtag_TDO, shreg_q[DR_MAX-1:1]};
                end
                if (tck_fall) begin
                    if (bit_q == len_q - 6'd1) begin
                        idx_d   = '0;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                        state_d = StPost;
                    end else begin
                        bit_d = bit_q + 6'd1;
                        tms_d = (bit_q + 6'd2 == len_q);
                        tdi_d = shreg_q[0];
                    end
                end
            end
            StPost: begin
                if (tck_fall) begin
                    if (idx_q == 3'd0) begin
                        idx_d = 3'd1;
                        tms_d = 1'b0;
                    end else begin
                        rsp_d   = shreg_q >> (DrMaxW - {1'b0, len_q});
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            type_q  <= JtagCmdReset;
            len_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            rsp_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StDone);
    assign rsp_data_o  = rsp_q;
    assign jtag_TMS    = tms_q;
    assign jtag_TDI    = tdi_q;

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host with a behavioural TAP model on the pins.
module tb_jtag_host;

    localparam int unsigned ClkDiv = 2;
    localparam int unsigned DrMax  = 40;
    localparam logic [39:0] DrCap  = 40'h12_3456_789A;
    localparam logic [4:0]  IrCap  = 5'b00001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [1:0]       cmd_type_i = 2'b00;
    logic [5:0]       cmd_len_i = '0;
    logic [DrMax-1:0] cmd_data_i = '0;
    logic             rsp_valid_o;
    logic [DrMax-1:0] rsp_data_o;
    logic             jtag_TCK, jtag_TMS, jtag_TDI;
    logic             jtag_TDO;

    int n_checks = 0;
    int n_errors = 0;

    jtag_host #(
        .CLK_DIV(ClkDiv),
        .IR_LEN (5),
        .DR_MAX (DrMax)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_type_i (cmd_type_i),
        .cmd_len_i  (cmd_len_i),
        .cmd_data_i (cmd_data_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_data_o (rsp_data_o),
        .jtag_TCK   (jtag_TCK),
        .jtag_TMS   (jtag_TMS),
        .jtag_TDI   (jtag_TDI),
        .jtag_TDO   (jtag_TDO)
    );

    always #5 clk = ~clk;

    // TAP model: states 0..15 in IEEE order (TLR, RTI, DR column, IR column).
    int          tap_st = 0;
    logic [39:0] dr_sr = '0, dr_upd = '0;
    logic [4:0]  ir_sr = '0, ir_upd = '0;
    logic        tdo_q = 1'b0;
    int          tck_rises = 0;
    int          n_tdi = 0;
    logic        tms_log [4096];
    logic        tdi_log [4096];

    assign jtag_TDO = tdo_q;

    function automatic int tap_next(input int s, input logic tms);
        int n;
        case (s)
            0:       n = tms ? 0 : 1;
            1:       n = tms ? 2 : 1;
            2:       n = tms ? 9 : 3;
            3, 4:    n = tms ? 5 : 4;
            5:       n = tms ? 8 : 6;
            6:       n = tms ? 7 : 6;
            7:       n = tms ? 8 : 4;
            8, 15:   n = tms ? 2 : 1;
            9:       n = tms ? 0 : 10;
            10, 11:  n = tms ? 12 : 11;
            12:      n = tms ? 15 : 13;
            13:      n = tms ? 14 : 13;
            default: n = tms ? 15 : 11;
        endcase
        return n;
    endfunction

    always @(posedge jtag_TCK) begin
        tms_log[tck_rises % 4096] = jtag_TMS;
        tck_rises = tck_rises + 1;
        case (tap_st)
            3:  dr_sr = DrCap;
            4:  dr_sr = {jtag_TDI, dr_sr[39:1]};
            8:  dr_upd = dr_sr;
            10: ir_sr = IrCap;
            11: ir_sr = {jtag_TDI, ir_sr[4:1]};
            15: ir_upd = ir_sr;
            default: ;
        endcase
        if (tap_st == 4 || tap_st == 11) begin
            tdi_log[n_tdi % 4096] = jtag_TDI;
            n_tdi = n_tdi + 1;
        end
        tap_st = tap_next(tap_st, jtag_TMS);
    end

    always @(negedge jtag_TCK) begin
        tdo_q <= (tap_st == 4) ? dr_sr[0] : (tap_st == 11) ? ir_sr[0] : 1'b0;
    end

    // Pin discipline: TMS/TDI steady while TCK high, no TCK movement while idle.
    int   pin_viol = 0;
    int   idle_edges = 0;
    logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (jtag_TCK && (jtag_TMS !== prev_tms || jtag_TDI !== prev_tdi)) pin_viol++;
            if (jtag_TCK !== prev_tck && cmd_ready_o) idle_edges++;
        end
        prev_tck = jtag_TCK;
        prev_tms = jtag_TMS;
        prev_tdi = jtag_TDI;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command; report latency (negedges after acceptance up to the
    // rsp_valid sample), response data, TCK rises and per-rise TMS/TDI bits.
    task automatic issue(input logic [1:0] typ, input logic [5:0] len,
                         input logic [39:0] data, output int lat, output logic [39:0] rsp,
                         output int rises, output logic [63:0] tms_v, output logic [63:0] tdi_v);
        int guard;
        int r0;
        int t0;
        @(negedge clk);
        cmd_type_i  = typ;
        cmd_len_i   = len;
        cmd_data_i  = data;
        cmd_valid_i = 1'b1;
        guard = 0;
        while (!cmd_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        r0 = tck_rises;
        t0 = n_tdi;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            cmd_valid_i = 1'b0;
            lat++;
        end while (!rsp_valid_o && lat < 400);
        rsp   = rsp_data_o;
        rises = tck_rises - r0;
        tms_v = '0;
        tdi_v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < rises) tms_v[i] = tms_log[(r0 + i) % 4096];
            if (i < n_tdi - t0) tdi_v[i] = tdi_log[(t0 + i) % 4096];
        end
    endtask

    initial begin
        int          lat;
        int          rises;
        int          vcnt;
        logic [39:0] rsp;
        logic [63:0] tms_v, tdi_v;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(cmd_ready_o), 64'd1);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data_o), 64'd0);
        check_eq("rst_tck", 64'(jtag_TCK), 64'd0);
        check_eq("rst_tms", 64'(jtag_TMS), 64'd1);
        check_eq("rst_tdi", 64'(jtag_TDI), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // TAP reset: 6 TCK cycles, valid at 1 + 2*6*2.
        issue(2'b00, 6'd0, 40'h0, lat, rsp, rises, tms_v, tdi_v);
        check_eq("reset_latency", 64'(lat), 64'd25);
        check_eq("reset_rsp", 64'(rsp), 64'd0);
        check_eq("reset_rises", 64'(rises), 64'd6);
        check_eq("reset_tms", tms_v, 64'h1F);
        check_eq("reset_tap_idle", 64'(tap_st), 64'd1);
        @(negedge clk);
        check_eq("reset_tms_rest", 64'(jtag_TMS), 64'd0);

        // IR scan len 5, data 5'h11.
        issue(2'b01, 6'd5, 40'h11, lat, rsp, rises, tms_v, tdi_v);
        check_eq("ir_latency", 64'(lat), 64'd45);
        check_eq("ir_rises", 64'(rises), 64'd11);
        check_eq("ir_tms", tms_v, 64'h303);
        check_eq("ir_tdi", tdi_v, 64'h11);
        check_eq("ir_rsp", 64'(rsp), 64'(IrCap));
        check_eq("ir_update", 64'(ir_upd), 64'h11);
        check_eq("ir_tap_idle", 64'(tap_st), 64'd1);

        // DR scan len 40.
        issue(2'b10, 6'd40, 40'hA5_C3F0_0F5A, lat, rsp, rises, tms_v, tdi_v);
        check_eq("dr40_latency", 64'(lat), 64'd181);
        check_eq("dr40_rises", 64'(rises), 64'd45);
        check_eq("dr40_rsp", 64'(rsp), 64'(DrCap));
        check_eq("dr40_update", 64'(dr_upd), 64'hA5_C3F0_0F5A);
        repeat (10) @(negedge clk);
        check_eq("dr40_rsp_hold", 64'(rsp_data_o), 64'(DrCap));

        // DR scan len 0: straight to DONE, no TCK, data cleared.
        issue(2'b10, 6'd0, 40'hFF, lat, rsp, rises, tms_v, tdi_v);
        check_eq("dr0_latency", 64'(lat), 64'd1);
        check_eq("dr0_rises", 64'(rises), 64'd0);
        check_eq("dr0_rsp", 64'(rsp), 64'd0);

        // DR scan len 50 clamps to 40.
        issue(2'b10, 6'd50, 40'h01_0203_0405, lat, rsp, rises, tms_v, tdi_v);
        check_eq("dr50_latency", 64'(lat), 64'd181);
        check_eq("dr50_rises", 64'(rises), 64'd45);
        check_eq("dr50_rsp", 64'(rsp), 64'(DrCap));
        check_eq("dr50_update", 64'(dr_upd), 64'h01_0203_0405);

        // Encoding 2'b11 behaves as reset.
        issue(2'b11, 6'd9, 40'h0, lat, rsp, rises, tms_v, tdi_v);
        check_eq("type3_latency", 64'(lat), 64'd25);
        check_eq("type3_tms", tms_v, 64'h1F);

        // Back-to-back DR len 8 with cmd_valid_i held high.
        @(negedge clk);
        cmd_type_i  = 2'b10;
        cmd_len_i   = 6'd8;
        cmd_data_i  = 40'h55;
        cmd_valid_i = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid_o && lat < 400);
        check_eq("b2b_first_latency", 64'(lat), 64'd53);
        check_eq("b2b_first_rsp", 64'(rsp_data_o), 64'h9A);
        @(negedge clk);
        check_eq("b2b_ready_after_rsp", 64'(cmd_ready_o), 64'd1);
        @(negedge clk);
        check_eq("b2b_second_accepted", 64'(cmd_ready_o), 64'd0);
        cmd_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b2b_second_latency", 64'(lat), 64'd53);
        check_eq("b2b_second_rsp", 64'(rsp_data_o), 64'h9A);

        // Abort mid-SHIFT: 23rd negedge after acceptance sits in shift bit 2, TCK high.
        @(negedge clk);
        cmd_type_i  = 2'b10;
        cmd_len_i   = 6'd40;
        cmd_data_i  = 40'hFF_FFFF_FFFF;
        cmd_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (22) @(negedge clk);
        check_eq("abort_pre_tck", 64'(jtag_TCK), 64'd1);
        check_eq("abort_pre_tms", 64'(jtag_TMS), 64'd0);
        check_eq("abort_pre_tdi", 64'(jtag_TDI), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_tck", 64'(jtag_TCK), 64'd0);
        check_eq("abort_tms", 64'(jtag_TMS), 64'd1);
        check_eq("abort_tdi", 64'(jtag_TDI), 64'd0);
        vcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid_o) vcnt++;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid_o) vcnt++;
        end
        check_eq("abort_no_rsp", 64'(vcnt), 64'd0);
        check_eq("abort_ready", 64'(cmd_ready_o), 64'd1);

        // Resynchronise the TAP model after the abort.
        issue(2'b00, 6'd0, 40'h0, lat, rsp, rises, tms_v, tdi_v);
        check_eq("resync_latency", 64'(lat), 64'd25);
        check_eq("resync_tap_idle", 64'(tap_st), 64'd1);

        check_eq("pin_stability", 64'(pin_viol), 64'd0);
        check_eq("idle_tck_edges", 64'(idle_edges), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
